// File: rtl/weight_input_buffer.sv
// Single first-word-fall-through FIFO with occupancy count and per-cycle error strobes.
// Latency: a push is visible at head one cycle later; a pop exposes the next entry right after the edge.
// Backpressure: none; a push while full without a same-cycle pop is dropped and flagged as overrun.
module weight_input_buffer_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 64,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] head,
    output logic              valid,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              overrun,
    output logic              underrun
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              do_push;
    logic              do_pop;

    assign valid    = (count != '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop & valid;
    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    assign do_push  = push & (~full | do_pop);
    assign overrun  = push & full & ~do_pop;
    assign underrun = pop & ~valid;
    assign head     = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end
endmodule

// Steers the register-block push stream into weight / input-activation FIFOs for the compute core.
// Latency: push to valid head in one cycle; status and counts are derived from registered state only.
// Backpressure: none upstream; overruns and underruns are recorded in sticky error bits until clr_err.
module weight_input_buffer #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 64,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              wr_en_push,
    input  logic              is_weight,
    input  logic [DATA_W-1:0] write_data,
    input  logic              w_pop,
    input  logic              i_pop,
    input  logic              clr_err,
    output logic [DATA_W-1:0] w_data,
    output logic              w_valid,
    output logic [DATA_W-1:0] i_data,
    output logic              i_valid,
    output logic [CNT_W-1:0]  w_count,
    output logic [CNT_W-1:0]  i_count,
    output logic              batch_ready,
    output logic [7:0]        status_out,
    output logic [15:0]       err_out
);
    logic w_full;
    logic i_full;
    logic w_over;
    logic w_under;
    logic i_over;
    logic i_under;
    logic [3:0] err_q;
    logic [3:0] err_new;

    weight_input_buffer_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) u_w_fifo (
        .clk      (clk),
        .n_rst    (n_rst),
        .push     (wr_en_push & is_weight),
        .pop      (w_pop),
        .din      (write_data),
        .head     (w_data),
        .valid    (w_valid),
        .count    (w_count),
        .full     (w_full),
        .overrun  (w_over),
        .underrun (w_under)
    );

    weight_input_buffer_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) u_i_fifo (
        .clk      (clk),
        .n_rst    (n_rst),
        .push     (wr_en_push & ~is_weight),
        .pop      (i_pop),
        .din      (write_data),
        .head     (i_data),
        .valid    (i_valid),
        .count    (i_count),
        .full     (i_full),
        .overrun  (i_over),
        .underrun (i_under)
    );

    assign err_new = {i_under, i_over, w_under, w_over};

    // New errors OR in after the clear so a same-cycle error survives clr_err.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            err_q <= '0;
        end else begin
            err_q <= (clr_err ? 4'b0 : err_q) | err_new;
        end
    end

    assign batch_ready = w_full & i_valid;
    assign status_out  = {3'b000, batch_ready, i_full, w_full, w_valid, i_valid};
    assign err_out     = {6'b0, err_q[3:2], 6'b0, err_q[1:0]};
endmodule

// File: tb/tb_weight_input_buffer.sv
module tb_weight_input_buffer;
    localparam int DEPTH  = 8;
    localparam int DATA_W = 64;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic              wr_en_push = 1'b0;
    logic              is_weight = 1'b0;
    logic [DATA_W-1:0] write_data = '0;
    logic              w_pop = 1'b0;
    logic              i_pop = 1'b0;
    logic              clr_err = 1'b0;
    logic [DATA_W-1:0] w_data;
    logic              w_valid;
    logic [DATA_W-1:0] i_data;
    logic              i_valid;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  i_count;
    logic              batch_ready;
    logic [7:0]        status_out;
    logic [15:0]       err_out;

    int checks = 0;
    int failures = 0;

    logic [DATA_W-1:0] wq[$];
    logic [DATA_W-1:0] iq[$];
    logic [15:0]       exp_err = '0;

    weight_input_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .wr_en_push  (wr_en_push),
        .is_weight   (is_weight),
        .write_data  (write_data),
        .w_pop       (w_pop),
        .i_pop       (i_pop),
        .clr_err     (clr_err),
        .w_data      (w_data),
        .w_valid     (w_valid),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .w_count     (w_count),
        .i_count     (i_count),
        .batch_ready (batch_ready),
        .status_out  (status_out),
        .err_out     (err_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full comparison of every output against the queue model.
    task automatic check_state(input string tag);
        logic wf, inf;
        wf  = (wq.size() == DEPTH);
        inf = (iq.size() == DEPTH);
        chk({tag, ":w_count"}, 64'(w_count), 64'(wq.size()));
        chk({tag, ":i_count"}, 64'(i_count), 64'(iq.size()));
        chk({tag, ":w_valid"}, 64'(w_valid), 64'(wq.size() != 0));
        chk({tag, ":i_valid"}, 64'(i_valid), 64'(iq.size() != 0));
        chk({tag, ":w_data"}, w_data, (wq.size() != 0) ? wq[0] : 64'h0);
        chk({tag, ":i_data"}, i_data, (iq.size() != 0) ? iq[0] : 64'h0);
        chk({tag, ":batch_ready"}, 64'(batch_ready), 64'(wf && iq.size() != 0));
        chk({tag, ":status"}, 64'(status_out),
            64'({3'b000, wf && iq.size() != 0, inf, wf, wq.size() != 0, iq.size() != 0}));
        chk({tag, ":err"}, 64'(err_out), 64'(exp_err));
    endtask

    // One clock of stimulus; pops are scored against the model before the edge.
    task automatic cyc(input bit p, input bit isw, input logic [63:0] d,
                       input bit wp, input bit ip, input bit clr, input string tag);
        bit w_do_pop, i_do_pop, w_full_m, i_full_m;
        logic [15:0] nerr;
        wr_en_push = p; is_weight = isw; write_data = d;
        w_pop = wp; i_pop = ip; clr_err = clr;
        w_full_m = (wq.size() == DEPTH);
        i_full_m = (iq.size() == DEPTH);
        w_do_pop = wp && wq.size() != 0;
        i_do_pop = ip && iq.size() != 0;
        nerr = '0;
        if (w_do_pop) begin
            chk({tag, ":w_pop_data"}, w_data, wq[0]);
            void'(wq.pop_front());
        end
        if (i_do_pop) begin
            chk({tag, ":i_pop_data"}, i_data, iq[0]);
            void'(iq.pop_front());
        end
        if (wp && !w_do_pop) nerr[1] = 1'b1;
        if (ip && !i_do_pop) nerr[9] = 1'b1;
        if (p && isw) begin
            if (!w_full_m || w_do_pop) wq.push_back(d); else nerr[0] = 1'b1;
        end
        if (p && !isw) begin
            if (!i_full_m || i_do_pop) iq.push_back(d); else nerr[8] = 1'b1;
        end
        exp_err = (clr ? 16'h0 : exp_err) | nerr;
        @(posedge clk);
        #1;
        wr_en_push = 0; is_weight = 0; write_data = '0;
        w_pop = 0; i_pop = 0; clr_err = 0;
        check_state(tag);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        check_state("post_reset");

        // Three weights, then two pops
        cyc(1, 1, 64'h11, 0, 0, 0, "push_w1");
        chk("first_push_head", w_data, 64'h11);
        cyc(1, 1, 64'h22, 0, 0, 0, "push_w2");
        cyc(1, 1, 64'h33, 0, 0, 0, "push_w3");
        chk("three_status", 64'(status_out), 64'h02);
        chk("three_count", 64'(w_count), 64'd3);
        cyc(0, 0, 0, 1, 0, 0, "pop_w1");
        cyc(0, 0, 0, 1, 0, 0, "pop_w2");
        chk("after_two_pops", w_data, 64'h33);
        cyc(0, 0, 0, 1, 0, 0, "pop_w3");

        // Overrun on a full weight FIFO
        for (int k = 0; k < DEPTH; k++)
            cyc(1, 1, {$urandom, $urandom}, 0, 0, 0, "fill_w");
        cyc(1, 1, 64'hDEAD, 0, 0, 0, "overrun_w");
        chk("overrun_err", 64'(err_out), 64'h0001);
        chk("overrun_full", 64'(status_out[2]), 64'd1);
        for (int k = 0; k < DEPTH; k++)
            cyc(0, 0, 0, 1, 0, 0, "drain_w");
        chk("drained_valid", 64'(w_valid), 64'd0);
        cyc(0, 0, 0, 0, 0, 1, "clr_err");
        chk("cleared_err", 64'(err_out), 64'h0);

        // batch_ready
        for (int k = 0; k < DEPTH; k++)
            cyc(1, 1, 64'(100 + k), 0, 0, 0, "fill_w2");
        cyc(1, 0, 64'hAB, 0, 0, 0, "push_i_ab");
        chk("batch_status", 64'(status_out), 64'h17);
        cyc(0, 0, 0, 0, 1, 0, "pop_i_ab");
        chk("batch_off", 64'(batch_ready), 64'd0);
        for (int k = 0; k < DEPTH; k++)
            cyc(0, 0, 0, 1, 0, 0, "drain_w2");

        // Input underrun and clr_err racing a new error
        cyc(0, 0, 0, 0, 1, 0, "underrun_i");
        chk("underrun_err", 64'(err_out), 64'h0200);
        cyc(0, 0, 0, 0, 1, 1, "clr_vs_underrun");
        chk("clr_race_err", 64'(err_out), 64'h0200);
        cyc(0, 0, 0, 0, 0, 1, "clr_err2");

        // Full input FIFO with simultaneous push and pop, across pointer wrap
        for (int k = 0; k < DEPTH; k++)
            cyc(1, 0, 64'(200 + k), 0, 0, 0, "fill_i");
        cyc(1, 0, 64'h99, 0, 1, 0, "full_push_pop");
        chk("full_pp_count", 64'(i_count), 64'd8);
        chk("full_pp_err", 64'(err_out), 64'h0);
        for (int k = 0; k < DEPTH - 1; k++)
            cyc(0, 0, 0, 0, 1, 0, "drain_i");
        chk("last_is_99", i_data, 64'h99);
        cyc(0, 0, 0, 0, 1, 0, "drain_i_last");

        // Empty push+pop: pop underruns, push lands; cross-FIFO independence
        cyc(1, 1, 64'h77, 1, 0, 0, "empty_pp");
        cyc(1, 0, 64'h55, 1, 0, 0, "cross_fifo");
        cyc(1, 1, 64'h66, 0, 1, 0, "cross_fifo2");

        // Asynchronous reset mid-stream
        for (int k = 0; k < 4; k++) begin
            cyc(1, 1, 64'(300 + k), 0, 0, 0, "half_w");
            cyc(1, 0, 64'(400 + k), 0, 0, 0, "half_i");
        end
        #2;
        n_rst = 1'b0;
        #1;
        wq.delete();
        iq.delete();
        exp_err = '0;
        check_state("async_reset");
        #3;
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        cyc(1, 1, 64'h5, 0, 0, 0, "push_after_rst");
        chk("head_after_rst", w_data, 64'h5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/weight_input_buffer.md
Name: weight_input_buffer

Overview:
- Sits directly downstream of the AHB subordinate register block in the AI accelerator.
- Consumes its push stream (wr_en_push, is_weight, write_data) and steers each 64-bit word into one of two first-word-fall-through FIFOs: weight or input-activation.
- Presents both FIFO heads to the compute core through valid/pop handshakes.
- Returns occupancy status and sticky overrun/underrun error bits, formatted for the subordinate's status_reg and err_reg inputs.

Parameters:
- DEPTH, 8, entries per FIFO; power of two, 2..64.
- DATA_W, 64, word width.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width.

Ports:
- clk  in  1  clock
- n_rst  in  1  reset
- wr_en_push  in  1  single-cycle push strobe from upstream
- is_weight  in  1  1 = push targets weight FIFO, 0 = input FIFO
- write_data  in  DATA_W  push word
- w_pop  in  1  compute core consumes weight head
- i_pop  in  1  compute core consumes input head
- clr_err  in  1  clears all sticky error bits
- w_data  out  DATA_W  weight FIFO head
- w_valid  out  1  weight FIFO non-empty
- i_data  out  DATA_W  input FIFO head
- i_valid  out  1  input FIFO non-empty
- w_count  out  CNT_W  weight occupancy
- i_count  out  CNT_W  input occupancy
- batch_ready  out  1  weight FIFO full and input FIFO non-empty
- status_out  out  8  [0] i_valid, [1] w_valid, [2] w_full, [3] i_full, [4] batch_ready, [7:5] 0
- err_out  out  16  [0] weight overrun, [1] weight underrun, [8] input overrun, [9] input underrun; all other bits 0

Behaviour:
- Interface: reset n_rst, asynchronous, active-low; clock clk.
- Reset values: both FIFOs empty; read/write pointers 0; w_count = i_count = 0; w_valid = i_valid = 0; batch_ready = 0; status_out = 0; err_out = 0. w_data and i_data read 0 while empty.
- Push rules:
  - Every cycle with wr_en_push = 1 is one push; the upstream block guarantees a one-cycle strobe per AHB write.
  - Target is the weight FIFO if is_weight = 1, else the input FIFO.
  - Word is stored at the target's write pointer on that clock edge; the pointer wraps from DEPTH-1 to 0.
- Push latency: a push into an empty FIFO makes valid = 1 and data = the pushed word in the following cycle.
- Pop rules:
  - A pop with valid = 1 retires the head at the clock edge and advances the read pointer with wrap.
  - The next entry, or 0 if now empty, appears combinationally after that edge.
- Counters: count increments on a push, decrements on a pop, and is unchanged on a simultaneous push and pop. full is count == DEPTH.
- Simultaneous push and pop on the same FIFO:
  - Both are honoured, including when the FIFO is full; the pop frees the slot in the same cycle.
  - On an empty FIFO, the pop is an underrun (valid = 0 at the time) and the push still succeeds.
- Overrun: a push to a full FIFO without a same-cycle pop on that FIFO is dropped. Storage, pointers and count are unchanged, and the overrun bit for that FIFO sets.
- Underrun: a pop while valid = 0 is ignored (no pointer or count change) and the underrun bit for that FIFO sets.
- Sticky errors:
  - err_out bits hold 1 until clr_err = 1.
  - clr_err clears them on the next edge.
  - A new error in the same cycle as clr_err wins: its bit reads 1 afterwards.
- The two FIFOs are fully independent; a push to one and a pop from the other in the same cycle both complete.
- Outputs w_count, i_count, status_out and batch_ready are registered-state derived, with no combinational path from the push or pop inputs.
- Reset mid-operation: all contents are discarded and all outputs return to their reset values immediately (asynchronous).

Test Plan:
- After reset, push 3 weights 0x11, 0x22, 0x33 (is_weight = 1) -> w_count = 3, w_data = 0x11, i_valid = 0, status_out = 0x02; pop twice -> w_data = 0x33, w_count = 1.
- Push 8 weights, then a 9th weight 0xDEAD -> w_count = 8, status_out[2] = 1, err_out = 0x0001, 0xDEAD never appears at w_data; pop 8 -> original order, w_valid = 0; clr_err -> err_out = 0.
- Fill the weight FIFO (8) and push one input 0xAB -> batch_ready = 1, status_out = 0x17; then pop the input -> batch_ready = 0.
- i_pop while the input FIFO is empty -> err_out = 0x0200, i_count stays 0; simultaneous clr_err plus a new i_pop underrun -> err_out stays 0x0200.
- Fill the input FIFO, then push input 0x99 together with i_pop -> no overrun, i_count stays 8, and 0x99 emerges as the 8th pop after the wrapped pointer.
- Assert n_rst mid-stream with both FIFOs half full -> all counts, valid, status_out and err_out are 0 immediately; next push 0x5 -> it becomes the head next cycle.
